branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Execute-side partner of the global branch predictor.
- Carries each fetch-stage prediction (found flag, predicted next PC) through the F/D and D/E pipeline registers.
- In EXE, compares the prediction against the actual branch outcome. Produces the predictor update pair (branch_found_EXE, branch_taken_EXE), the mispredict redirect PC and the front-end flush.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
ADDR_WIDTH, 32, PC / target width
CNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low (sampled on rising clk edge)
pc_f  in  ADDR_WIDTH  fetch PC
branchfound_f  in  1  predictor BTB hit for pc_f
predict_pc_f  in  ADDR_WIDTH  predictor next-PC for pc_f
stall_d  in  1  hold F/D register
bubble_e  in  1  load bubble into D/E (load-use stall)
is_branch_e  in  1  instruction in EXE is a conditional branch
branch_taken_e  in  1  actual outcome in EXE
pcbranch_e  in  ADDR_WIDTH  actual branch target in EXE
pc_e  out  ADDR_WIDTH  PC held in D/E
branch_found_EXE  out  1  predictor update: BTB hit recorded for EXE instruction
branch_taken_EXE  out  1  predictor update: actual taken
mispredict_e  out  1  redirect request this cycle
mispredict_pc_e  out  ADDR_WIDTH  correct next PC
flush_fd  out  1  squash F/D contents
branch_cnt  out  CNT_WIDTH  resolved branches
mispredict_cnt  out  CNT_WIDTH  redirects issued

Behaviour:
- Pipeline registers: FD = {valid, pc, found, ppc}; DE = same fields. A "bubble" is valid=0 with all other fields 0.
- Reset (rst_n=0 at edge):
  - FD and DE become bubbles.
  - Both counters go to 0.
  - FSM goes to RUN.
  - All outputs go to 0.
- FD update priority: reset > flush (bubble) > stall_d (hold) > load {1, pc_f, branchfound_f, predict_pc_f}.
- DE update priority: reset > flush (bubble) > bubble_e (bubble) > load FD.
- FSM:
  - RUN: evaluate EXE. If mispredict_e=1, go to RECOVER at the next edge.
  - RECOVER: exactly one cycle. Outputs mispredict_e=0, branch_found_EXE=0, branch_taken_EXE=0; counters hold. Return to RUN.
- EXE evaluation (combinational from DE plus inputs, RUN state only, DE.valid=1):
  - actual_next = (is_branch_e & branch_taken_e) ? pcbranch_e : pc_e+4, with modulo-2^ADDR_WIDTH wrap.
  - pred_next = DE.found ? DE.ppc : pc_e+4.
  - mispredict_e = (actual_next != pred_next). This covers a BTB alias hit on a non-branch: redirect to pc_e+4.
  - mispredict_pc_e = actual_next when mispredict_e=1, else 0.
  - branch_found_EXE = is_branch_e & DE.found.
  - branch_taken_EXE = is_branch_e & branch_taken_e.
- Flush: flush_fd = mispredict_e, same cycle. At the next edge FD and DE become bubbles, overriding stall_d and bubble_e.
- Counters update at the edge and saturate at all-ones (no wrap):
  - branch_cnt increments when valid & RUN & is_branch_e.
  - mispredict_cnt increments when mispredict_e.
- bubble_e combined with a mispredict: the flush wins, and both counters still count the resolving instruction.
- DE.valid=0: all EXE outputs are 0 and nothing is counted.
- Reset asserted during RECOVER: forces RUN with empty pipeline; no pending flush survives.

Decomposition:
- Shared package bp_pkg:
  - pipeline-entry struct {valid, pc, found, ppc};
  - FSM state enum {RUN, RECOVER};
  - PC_STEP = 4.
- One natural sub-module: sat_counter (CNT_WIDTH, synchronous active-low reset, inc enable, saturate), instantiated twice.
- Pipeline registers and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0, counters 0; the first valid instruction reaches EXE 2 cycles after its fetch.
- Correct taken prediction: pc_f=0x100, branchfound_f=1, predict_pc_f=0x200; in EXE is_branch_e=1, taken=1, pcbranch_e=0x200 -> mispredict_e=0, found/taken=1/1, branch_cnt=1.
- BTB miss, taken: pc_f=0x40, found=0; EXE taken to 0x80 -> mispredict_e=1, mispredict_pc_e=0x80, flush_fd=1; next cycle RECOVER with all outputs 0; mispredict_cnt=1.
- Hit, not taken, plus BTB alias: found=1, ppc=0x300, EXE not taken at pc_e=0x10 -> redirect 0x14. Repeat with is_branch_e=0 -> redirect 0x14, branch_found_EXE=0.
- Stall/flush priority: stall_d=1 and bubble_e=1 in the same cycle as a mispredict -> FD and DE are bubbles next cycle. Then stall_d=1 alone for 3 cycles -> FD held, pc_e unchanged.
- Saturation/wrap: force counters to all-ones and resolve a mispredict -> counters stay all-ones. Use pc_e=0xFFFFFFFC, not taken, with ppc pointing elsewhere -> mispredict_pc_e=0x0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the execute-side branch resolution logic: pipeline entry
// carried from fetch to execute, resolver FSM states and the sequential PC step.
package bp_pkg;

   localparam int unsigned PC_WIDTH = 32;
   localparam int unsigned PC_STEP  = 4;

   typedef logic [PC_WIDTH-1:0] pc_t;

   // Fetch-time prediction travelling alongside the instruction; all-zero is a bubble.
   typedef struct packed {
      logic valid;
      pc_t  pc;
      logic found;
      pc_t  ppc;
   } pipe_entry_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Statistics counter that increments on demand and sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // NOTE: combinational next-state uses blocking '=' with a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !(&cnt_q)) cnt_d = cnt_q + WIDTH'(1);
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch-stage predictions to EXE, checks them against the real outcome,
// drives predictor update / redirect / front-end flush and keeps statistics.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = PC_WIDTH,  // must match bp_pkg::PC_WIDTH
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] pc_f,
   input  logic                  branchfound_f,
   input  logic [ADDR_WIDTH-1:0] predict_pc_f,
   input  logic                  stall_d,
   input  logic                  bubble_e,
   input  logic                  is_branch_e,
   input  logic                  branch_taken_e,
   input  logic [ADDR_WIDTH-1:0] pcbranch_e,
   output logic [ADDR_WIDTH-1:0] pc_e,
   output logic                  branch_found_EXE,
   output logic                  branch_taken_EXE,
   output logic                  mispredict_e,
   output logic [ADDR_WIDTH-1:0] mispredict_pc_e,
   output logic                  flush_fd,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

   pipe_entry_t fd_q, fd_d;
   pipe_entry_t de_q, de_d;
   bru_state_e  state_q;

   pc_t  pc_plus_step;
   pc_t  actual_next;
   pc_t  pred_next;
   logic exe_active;
   logic mispredict;

   always_comb begin
      pc_plus_step = de_q.pc + pc_t'(PC_STEP);
      actual_next  = (is_branch_e && branch_taken_e) ? pcbranch_e : pc_plus_step;
      pred_next    = de_q.found ? de_q.ppc : pc_plus_step;
      exe_active   = (state_q == RUN) && de_q.valid;
      // A BTB alias hit on a non-branch also lands here and redirects to pc+4.
      mispredict   = exe_active && (actual_next != pred_next);

      fd_d = fd_q;
      if (mispredict)    fd_d = '0;
      else if (!stall_d) fd_d = '{valid: 1'b1, pc: pc_f, found: branchfound_f, ppc: predict_pc_f};

      de_d = (mispredict || bubble_e) ? '0 : fd_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fd_q    <= '0;
         de_q    <= '0;
         state_q <= RUN;
      end else begin
         fd_q <= fd_d;
         de_q <= de_d;
         unique case (state_q)
            RUN:     if (mispredict) state_q <= RECOVER;
            RECOVER: state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign pc_e             = de_q.pc;
   assign branch_found_EXE = exe_active && is_branch_e && de_q.found;
   assign branch_taken_EXE = exe_active && is_branch_e && branch_taken_e;
   assign mispredict_e     = mispredict;
   assign mispredict_pc_e  = mispredict ? actual_next : '0;
   assign flush_fd         = mispredict;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (exe_active && is_branch_e),
      .cnt_o (branch_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (mispredict),
      .cnt_o (mispredict_cnt)
   );

endmodule
